// File: rtl/regfile_write_scheduler.sv
// Purpose : owns the register-file write port; zero-sweeps registers 1..REG_COUNT-1 after reset/REINIT, then round-robins two writeback requesters.
// Latency : a handshake in cycle N appears on WE3/A3/WD3 in cycle N+1 (all three are registered).
// Backpr. : READY is combinational from VALID and the grant pointer; both READYs are low while sweeping or when REINIT is high.
module regfile_write_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_COUNT  = 32
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  REINIT,
    input  logic                  REQ0_VALID,
    input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ0_DATA,
    output logic                  REQ0_READY,
    input  logic                  REQ1_VALID,
    input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ1_DATA,
    output logic                  REQ1_READY,
    output logic                  WE3,
    output logic [ADDR_WIDTH-1:0] A3,
    output logic [DATA_WIDTH-1:0] WD3,
    output logic                  INIT_DONE
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    // Register 0 is hardwired zero, so the sweep starts at 1.
    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(REG_COUNT - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [ADDR_WIDTH-1:0]   w_idx_nxt;
    // r_last = 1 means requester 1 was granted most recently, so requester 0 wins the next tie.
    logic                    r_last;
    logic                    w_last_nxt;
    logic                    r_we;
    logic                    w_we_nxt;
    logic [ADDR_WIDTH-1:0]   r_a;
    logic [ADDR_WIDTH-1:0]   w_a_nxt;
    logic [DATA_WIDTH-1:0]   r_wd;
    logic [DATA_WIDTH-1:0]   w_wd_nxt;
    logic                    r_done;
    logic                    w_done_nxt;

    logic                    w_rdy0;
    logic                    w_rdy1;
    logic                    w_hs0;
    logic                    w_hs1;

    // Round-robin grant: only when arbitrating and no re-sweep is being requested.
    always_comb begin
        w_rdy0 = 1'b0;
        w_rdy1 = 1'b0;
        if (r_state == ST_ARB && !REINIT) begin
            if (REQ0_VALID && REQ1_VALID) begin
                w_rdy0 = r_last;
                w_rdy1 = ~r_last;
            end else begin
                w_rdy0 = REQ0_VALID;
                w_rdy1 = REQ1_VALID;
            end
        end
    end

    assign w_hs0 = REQ0_VALID & w_rdy0;
    assign w_hs1 = REQ1_VALID & w_rdy1;

    // Next-state and next-output logic for the sweep/arbitrate FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        w_we_nxt    = 1'b0;
        w_a_nxt     = r_a;
        w_wd_nxt    = r_wd;
        w_done_nxt  = r_done;
        case (r_state)
            ST_INIT: begin
                // One zero write per cycle; REINIT has no effect while sweeping.
                w_we_nxt = 1'b1;
                w_a_nxt  = r_idx;
                w_wd_nxt = '0;
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = ST_ARB;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + FIRST_IDX;
                end
            end
            ST_ARB: begin
                if (REINIT) begin
                    // Re-sweep takes priority over any pending request; pointer is kept.
                    w_state_nxt = ST_INIT;
                    w_idx_nxt   = FIRST_IDX;
                    w_done_nxt  = 1'b0;
                end else if (w_hs0) begin
                    // Address 0 is accepted but never written.
                    w_we_nxt   = (REQ0_ADDR != '0);
                    w_a_nxt    = REQ0_ADDR;
                    w_wd_nxt   = REQ0_DATA;
                    w_last_nxt = 1'b0;
                end else if (w_hs1) begin
                    w_we_nxt   = (REQ1_ADDR != '0);
                    w_a_nxt    = REQ1_ADDR;
                    w_wd_nxt   = REQ1_DATA;
                    w_last_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_idx_nxt   = FIRST_IDX;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    // State, pointer and registered write-port outputs; reset restarts the sweep.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_INIT;
            r_idx   <= FIRST_IDX;
            r_last  <= 1'b1;
            r_we    <= 1'b0;
            r_a     <= '0;
            r_wd    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
            r_we    <= w_we_nxt;
            r_a     <= w_a_nxt;
            r_wd    <= w_wd_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign REQ0_READY = w_rdy0;
    assign REQ1_READY = w_rdy1;
    assign WE3        = r_we;
    assign A3         = r_a;
    assign WD3        = r_wd;
    assign INIT_DONE  = r_done;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Purpose : self-checking bench for regfile_write_scheduler (sweep, round-robin, addr-0, REINIT, async reset).
// Latency : expected write-port values are queued when a vector is driven and compared one edge later.
// Backpr. : READY expectations come from the vector table or the hand-written corner sequences.
module tb_regfile_write_scheduler;

    logic        CLK;
    logic        RST_N;
    logic        REINIT;
    logic        REQ0_VALID;
    logic [4:0]  REQ0_ADDR;
    logic [31:0] REQ0_DATA;
    logic        REQ0_READY;
    logic        REQ1_VALID;
    logic [4:0]  REQ1_ADDR;
    logic [31:0] REQ1_DATA;
    logic        REQ1_READY;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        INIT_DONE;

    regfile_write_scheduler #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .REG_COUNT (32)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REINIT    (REINIT),
        .REQ0_VALID(REQ0_VALID),
        .REQ0_ADDR (REQ0_ADDR),
        .REQ0_DATA (REQ0_DATA),
        .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID),
        .REQ1_ADDR (REQ1_ADDR),
        .REQ1_DATA (REQ1_DATA),
        .REQ1_READY(REQ1_READY),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3),
        .INIT_DONE (INIT_DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        reinit;
        logic        r0;
        logic        r1;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  a;
        logic [31:0] wd;
        logic        done;
    } exp_t;

    vec_t        tbl [11];
    exp_t        sb [$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [4:0]  m_a;
    logic [31:0] m_wd;
    vec_t        both_v;
    vec_t        rein_v;
    bit          found;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge: drive one vector, check READY mid-cycle,
    // queue the expected write-port values and compare them after the next edge.
    task automatic apply(input vec_t v);
        exp_t e;
        exp_t g;
        REQ0_VALID = v.v0;
        REQ0_ADDR  = v.a0;
        REQ0_DATA  = v.d0;
        REQ1_VALID = v.v1;
        REQ1_ADDR  = v.a1;
        REQ1_DATA  = v.d1;
        REINIT     = v.reinit;
        #3;
        chk("req0_ready", 32'(REQ0_READY), 32'(v.r0));
        chk("req1_ready", 32'(REQ1_READY), 32'(v.r1));
        e.we   = 1'b0;
        e.a    = m_a;
        e.wd   = m_wd;
        e.done = !v.reinit;
        if (!v.reinit && v.v0 && v.r0) begin
            e.we = (v.a0 != 5'd0);
            e.a  = v.a0;
            e.wd = v.d0;
        end else if (!v.reinit && v.v1 && v.r1) begin
            e.we = (v.a1 != 5'd0);
            e.a  = v.a1;
            e.wd = v.d1;
        end
        m_a  = e.a;
        m_wd = e.wd;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            g = sb.pop_front();
            chk("we3", 32'(WE3), 32'(g.we));
            chk("a3", 32'(A3), 32'(g.a));
            chk("wd3", WD3, g.wd);
            chk("init_done", 32'(INIT_DONE), 32'(g.done));
        end
    endtask

    // Expects the sweep to begin on the next rising edge; returns just after edge 31.
    task automatic sweep_check();
        for (int k = 1; k <= 31; k++) begin
            @(posedge CLK);
            #1;
            chk("sweep_we3", 32'(WE3), 32'd1);
            chk("sweep_a3", 32'(A3), 32'(k));
            chk("sweep_wd3", WD3, 32'd0);
            chk("sweep_done", 32'(INIT_DONE), (k == 31) ? 32'd1 : 32'd0);
            if (k < 31) begin
                chk("sweep_rdy0", 32'(REQ0_READY), 32'd0);
                chk("sweep_rdy1", 32'(REQ1_READY), 32'd0);
            end
        end
        m_a  = 5'd31;
        m_wd = 32'd0;
    endtask

    initial begin
        // v0 a0 d0 | v1 a1 d1 | reinit | expected r0 r1
        tbl[0]  = '{1'b1, 5'd3, 32'h11,       1'b1, 5'd4, 32'h22,       1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 5'd3, 32'h11,       1'b1, 5'd4, 32'h22,       1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 5'd3, 32'h11,       1'b1, 5'd4, 32'h22,       1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 5'd3, 32'h11,       1'b1, 5'd4, 32'h22,       1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h77,       1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 5'd3, 32'h11,       1'b1, 5'd9, 32'h99,       1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 5'd0, 32'h55,       1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0};

        m_a  = 5'd0;
        m_wd = 32'd0;

        // Reset with both requesters valid: everything must stay quiet.
        RST_N      = 1'b0;
        REINIT     = 1'b0;
        REQ0_VALID = 1'b1;
        REQ0_ADDR  = 5'd3;
        REQ0_DATA  = 32'h11;
        REQ1_VALID = 1'b1;
        REQ1_ADDR  = 5'd4;
        REQ1_DATA  = 32'h22;
        #12;
        chk("rst_we3", 32'(WE3), 32'd0);
        chk("rst_a3", 32'(A3), 32'd0);
        chk("rst_wd3", WD3, 32'd0);
        chk("rst_done", 32'(INIT_DONE), 32'd0);
        chk("rst_rdy0", 32'(REQ0_READY), 32'd0);
        chk("rst_rdy1", 32'(REQ1_READY), 32'd0);
        @(negedge CLK);
        RST_N      = 1'b1;
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        sweep_check();

        // Arbitration table, starting in the cycle INIT_DONE rises.
        for (int i = 0; i < 11; i++) apply(tbl[i]);
        @(posedge CLK);
        #1;
        chk("idle_we3", 32'(WE3), 32'd0);

        // REINIT while both requesters are valid (pointer now favours requester 1).
        both_v = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 1'b0, 1'b1};
        rein_v = both_v;
        rein_v.reinit = 1'b1;
        rein_v.r0     = 1'b0;
        rein_v.r1     = 1'b0;
        apply(rein_v);
        REINIT = 1'b0;
        sweep_check();
        apply(both_v);

        // Async reset in the middle of a sweep.
        rein_v.v0 = 1'b0;
        rein_v.v1 = 1'b0;
        apply(rein_v);
        REINIT = 1'b0;
        found  = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge CLK);
            #1;
            if (A3 == 5'd10) found = 1'b1;
        end
        chk("midsweep_reached_a3_10", 32'(found), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_rst_we3", 32'(WE3), 32'd0);
        chk("async_rst_a3", 32'(A3), 32'd0);
        chk("async_rst_wd3", WD3, 32'd0);
        chk("async_rst_done", 32'(INIT_DONE), 32'd0);
        @(negedge CLK);
        RST_N      = 1'b1;
        REQ0_VALID = 1'b1;
        REQ1_VALID = 1'b1;
        sweep_check();
        // Pointer is back at its reset value, so requester 0 wins.
        both_v.r0 = 1'b1;
        both_v.r1 = 1'b0;
        apply(both_v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Write-port scheduler for the 32-entry register file. After reset it sweeps every writable register to zero through the single write port, then shares that port between two writeback requesters (ALU result path and load/memory result path) using valid/ready handshakes and round-robin arbitration. It sits between the writeback sources and the register file's WE3/A3/WD3 inputs and drives them from registers.

## Interface
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 5, register address width
- REG_COUNT, 32, number of registers; register 0 is hardwired zero and never written
- CLK  in  1  single clock; all state updates on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- REINIT  in  1  single-cycle request to re-run the zero sweep
- REQ0_VALID  in  1  requester 0 (ALU) has a write
- REQ0_ADDR  in  ADDR_WIDTH  requester 0 destination
- REQ0_DATA  in  DATA_WIDTH  requester 0 data
- REQ0_READY  out  1  requester 0 write accepted this cycle
- REQ1_VALID / REQ1_ADDR / REQ1_DATA / REQ1_READY: same for requester 1 (load path)
- WE3  out  1  register-file write enable (registered)
- A3  out  ADDR_WIDTH  register-file write address (registered)
- WD3  out  DATA_WIDTH  register-file write data (registered)
- INIT_DONE  out  1  sweep complete; arbitration active

## Operation
- States: INIT (sweep) and ARB (arbitrate). Reset enters INIT with sweep index = 1 and last-grant pointer = 1, so requester 0 wins the first contention.
- INIT: each edge loads WE3=1, A3=index, WD3=0. If index = REG_COUNT-1, go to ARB and set INIT_DONE=1 on that edge; otherwise increment index. Both READY outputs are 0 in INIT. REINIT is ignored in INIT.
- ARB: both READY outputs are combinational from current VALIDs and pointer:
  - Only one VALID high: that requester gets READY=1.
  - Both high: grant the requester that was not granted last. Pointer updates only on an accepted handshake.
  - No VALID high: both READY=0.
- A handshake is VALID & READY. On that edge: A3<=ADDR, WD3<=DATA, WE3<=(ADDR != 0). A write to address 0 is accepted (READY=1) but produces WE3=0.
- No handshake in ARB: WE3<=0; A3/WD3 hold previous values.
- REINIT=1 in ARB: both READY forced to 0 that cycle. On the edge, go to INIT with index=1, INIT_DONE<=0, WE3<=0. REINIT wins over any pending VALID.
- At most one write per cycle. Requesters hold VALID/ADDR/DATA stable until READY.

## Timing
- Reset values: WE3=0, A3=0, WD3=0, INIT_DONE=0; REQ0_READY=REQ1_READY=0 (state INIT). Reset takes effect immediately and asynchronously, including mid-sweep or mid-arbitration. Pointer and index return to reset values.
- Sweep: first edge after RST_N deasserts gives A3=1, WE3=1. After REG_COUNT-1 edges, A3=REG_COUNT-1 and INIT_DONE=1 together. READY can assert in that same cycle.
- Write latency: a handshake in cycle N puts the write on WE3/A3/WD3 in cycle N+1. The register file commits it on the edge ending cycle N+1.
- Throughput: one accepted write per cycle. With both VALIDs held high, grants alternate 0,1,0,1.
- REINIT asserted in cycle N: INIT_DONE=0 and WE3=0 in N+1; sweep writes A3=1 in N+2.

## Test plan
- Reset then idle (REG_COUNT=32) -> A3 = 1..31 with WE3=1 and WD3=0 on 31 consecutive cycles; INIT_DONE rises with A3=31; WE3=0 afterwards.
- After INIT_DONE, REQ0 alone with addr 5, data 0xDEADBEEF -> REQ0_READY=1 the same cycle; next cycle WE3=1, A3=5, WD3=0xDEADBEEF.
- Both VALIDs held for 4 cycles (REQ0 addr 3/data 0x11, REQ1 addr 4/data 0x22) -> grants 0,1,0,1; A3 sequence 3,4,3,4 one cycle later.
- REQ1 write to addr 0, data 0xFFFFFFFF -> REQ1_READY=1; next cycle WE3=0.
- REINIT pulsed while both VALIDs high -> both READY=0 that cycle; INIT_DONE=0 next cycle; sweep restarts at A3=1; requests are granted only after the new INIT_DONE.
- RST_N asserted mid-sweep (A3=10) -> outputs go to zero immediately; after release the sweep restarts at A3=1.
